// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer
//   Frame-synchronous test-pattern controller. Picks one of four colour
//   patterns from h_cnt/v_cnt, advances the pattern on a req/ack request or
//   automatically every AUTO_FRAMES frames, and only switches at the frame
//   boundary (h_cnt==0 && v_cnt==0) so no frame mixes two patterns.
// Ports
//   clk, rst           pixel clock, synchronous active-high reset
//   h_cnt, v_cnt       counters from the timing generator (11b)
//   next_req/next_ack  level request / one-cycle accept pulse
//   auto_en            enable auto-advance
//   pat_sel, pend      current pattern, advance waiting for frame boundary
//   o_r, o_g, o_b      registered 4-bit colour, one cycle behind h_cnt/v_cnt
module vga_pattern_sequencer #(
  parameter int unsigned H_ACT_START = 129,
  parameter int unsigned H_ACT_END   = 768,
  parameter int unsigned V_ACT_START = 36,
  parameter int unsigned V_ACT_END   = 515,
  parameter int unsigned AUTO_FRAMES = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] h_cnt,
  input  logic [10:0] v_cnt,
  input  logic        next_req,
  output logic        next_ack,
  input  logic        auto_en,
  output logic [1:0]  pat_sel,
  output logic        pend,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b
);

  localparam int unsigned CNT_W = 11;
  localparam int unsigned POS_W = 10;
  localparam int unsigned FRM_W = 12;
  localparam int unsigned RGB_W = 12;

  typedef enum logic {SHOW, PEND} state_t;

  state_t           state;
  logic [FRM_W-1:0] frame_cnt;

  logic             fb_c;
  logic             auto_exp_c;
  logic             pend_adv_c;
  logic             active_c;
  logic [POS_W-1:0] x_c;
  logic [POS_W-1:0] y_c;
  logic [2:0]       bar_x_c;
  logic [2:0]       bar_y_c;
  logic [RGB_W-1:0] pix_c;

  // Eight-colour bar palette, {r,g,b}
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    c = 12'h000;
    case (idx)
      3'd0: c = 12'hFFF;
      3'd1: c = 12'hF00;
      3'd2: c = 12'h0F0;
      3'd3: c = 12'h00F;
      3'd4: c = 12'h0FF;
      3'd5: c = 12'hF0F;
      3'd6: c = 12'hFF0;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  // Frame boundary and the two advance sources
  always_comb begin
    fb_c       = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    auto_exp_c = fb_c && auto_en && (frame_cnt == FRM_W'(AUTO_FRAMES - 1));
    pend_adv_c = fb_c && (state == PEND);
  end

  // Pixel colour from the pattern in effect this cycle
  always_comb begin
    active_c = (h_cnt >= CNT_W'(H_ACT_START)) && (h_cnt <= CNT_W'(H_ACT_END)) &&
               (v_cnt >= CNT_W'(V_ACT_START)) && (v_cnt <= CNT_W'(V_ACT_END));
    x_c      = POS_W'(h_cnt - CNT_W'(H_ACT_START));
    y_c      = POS_W'(v_cnt - CNT_W'(V_ACT_START));
    bar_x_c  = 3'(x_c / POS_W'(80));
    bar_y_c  = 3'(y_c / POS_W'(60));
    pix_c    = 12'h000;
    if (active_c) begin
      case (pat_sel)
        2'd0: pix_c = bar_colour(bar_x_c);
        2'd1: pix_c = bar_colour(bar_y_c);
        2'd2: pix_c = (x_c[5] ^ y_c[5]) ? 12'hFFF : 12'h000;
        default: pix_c = 12'hFFF;
      endcase
    end
  end

  // Handshake FSM, pattern select, auto frame counter and colour register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SHOW;
      pend      <= 1'b0;
      next_ack  <= 1'b0;
      pat_sel   <= 2'd0;
      frame_cnt <= '0;
      o_r       <= 4'h0;
      o_g       <= 4'h0;
      o_b       <= 4'h0;
    end else begin
      next_ack <= 1'b0;
      case (state)
        SHOW: begin
          if (next_req) begin
            next_ack <= 1'b1;
            state    <= PEND;
            pend     <= 1'b1;
          end
        end
        default: begin
          if (fb_c) begin
            state <= SHOW;
            pend  <= 1'b0;
          end
        end
      endcase

      // Coincident request and auto expiry still advance only once
      if (auto_exp_c || pend_adv_c) begin
        pat_sel <= pat_sel + 2'd1;
      end

      if (!auto_en || auto_exp_c || pend_adv_c) begin
        frame_cnt <= '0;
      end else if (fb_c) begin
        frame_cnt <= frame_cnt + FRM_W'(1);
      end

      o_r <= pix_c[11:8];
      o_g <= pix_c[7:4];
      o_b <= pix_c[3:0];
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb_vga_pattern_sequencer
//   Directed bench: a pixel vector table applied per pattern, plus hand-written
//   sequences for reset, handshake, auto-advance and frame-boundary collisions.
//   DUT runs with AUTO_FRAMES=2 so auto-advance is short.
module tb_vga_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        next_req;
  logic        next_ack;
  logic        auto_en;
  logic [1:0]  pat_sel;
  logic        pend;
  logic [3:0]  o_r;
  logic [3:0]  o_g;
  logic [3:0]  o_b;

  int total = 0;
  int bad   = 0;

  vga_pattern_sequencer #(
    .H_ACT_START(129), .H_ACT_END(768),
    .V_ACT_START(36),  .V_ACT_END(515),
    .AUTO_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .next_req(next_req), .next_ack(next_ack), .auto_en(auto_en),
    .pat_sel(pat_sel), .pend(pend), .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pat;
    logic [10:0] h;
    logic [10:0] v;
    logic [11:0] rgb;
  } pix_vec_t;

  pix_vec_t vecs[22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Park the counters mid-frame, away from the boundary
  task automatic mid();
    h_cnt = 11'd300;
    v_cnt = 11'd200;
  endtask

  // One frame-boundary cycle followed by a return to mid-frame
  task automatic fb();
    h_cnt = 11'd0;
    v_cnt = 11'd0;
    step();
    mid();
  endtask

  // Request an advance, probe the handshake, and cross a frame boundary
  task automatic advance(input logic [1:0] cur);
    next_req = 1'b1;
    step();
    chk("ack_pulse", 32'(next_ack), 32'd1);
    chk("pend_set", 32'(pend), 32'd1);
    step();
    chk("ack_once", 32'(next_ack), 32'd0);
    step();
    chk("ack_ignored", 32'(next_ack), 32'd0);
    chk("pat_hold", 32'(pat_sel), 32'(cur));
    next_req = 1'b0;
    step();
    fb();
    chk("pat_adv", 32'(pat_sel), 32'(cur + 2'd1));
    chk("pend_clr", 32'(pend), 32'd0);
  endtask

  initial begin
    logic [1:0] model_pat;
    rst = 1'b1; next_req = 1'b0; auto_en = 1'b0;
    mid();
    step(); step();
    rst = 1'b0;
    step();
    model_pat = 2'd0;

    vecs[0]  = '{2'd0, 11'd129, 11'd100, 12'hFFF};
    vecs[1]  = '{2'd0, 11'd209, 11'd100, 12'hF00};
    vecs[2]  = '{2'd0, 11'd768, 11'd100, 12'h000};
    vecs[3]  = '{2'd0, 11'd128, 11'd100, 12'h000};
    vecs[4]  = '{2'd0, 11'd449, 11'd100, 12'h0FF};
    vecs[5]  = '{2'd0, 11'd608, 11'd100, 12'hF0F};
    vecs[6]  = '{2'd0, 11'd688, 11'd100, 12'hFF0};
    vecs[7]  = '{2'd0, 11'd130, 11'd35,  12'h000};
    vecs[8]  = '{2'd0, 11'd130, 11'd36,  12'hFFF};
    vecs[9]  = '{2'd0, 11'd130, 11'd516, 12'h000};
    vecs[10] = '{2'd1, 11'd200, 11'd96,  12'hF00};
    vecs[11] = '{2'd1, 11'd200, 11'd215, 12'h0F0};
    vecs[12] = '{2'd1, 11'd200, 11'd336, 12'hF0F};
    vecs[13] = '{2'd1, 11'd200, 11'd515, 12'h000};
    vecs[14] = '{2'd1, 11'd200, 11'd95,  12'hFFF};
    vecs[15] = '{2'd2, 11'd160, 11'd36,  12'h000};
    vecs[16] = '{2'd2, 11'd161, 11'd36,  12'hFFF};
    vecs[17] = '{2'd2, 11'd161, 11'd68,  12'h000};
    vecs[18] = '{2'd2, 11'd768, 11'd515, 12'hFFF};
    vecs[19] = '{2'd3, 11'd300, 11'd200, 12'hFFF};
    vecs[20] = '{2'd3, 11'd769, 11'd200, 12'h000};
    vecs[21] = '{2'd3, 11'd129, 11'd515, 12'hFFF};

    // Pixel table, stepping the pattern through the handshake as needed
    for (int i = 0; i < 22; i++) begin
      while (model_pat != vecs[i].pat) begin
        advance(model_pat);
        model_pat = model_pat + 2'd1;
      end
      h_cnt = vecs[i].h;
      v_cnt = vecs[i].v;
      step();
      chk($sformatf("pix%0d", i), 32'({o_r, o_g, o_b}), 32'(vecs[i].rgb));
    end

    // Reset mid-frame while showing solid white
    mid();
    step();
    chk("pre_rst_pix", 32'({o_r, o_g, o_b}), 32'hFFF);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_pat", 32'(pat_sel), 32'd0);
      chk("rst_pend", 32'(pend), 32'd0);
      chk("rst_ack", 32'(next_ack), 32'd0);
      chk("rst_pix", 32'({o_r, o_g, o_b}), 32'd0);
    end
    rst = 1'b0;
    step();

    // Reset while an advance is pending discards it
    next_req = 1'b1;
    step();
    chk("pend_before_rst", 32'(pend), 32'd1);
    next_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pend_clr", 32'(pend), 32'd0);
    fb();
    chk("rst_pend_no_adv", 32'(pat_sel), 32'd0);

    // Auto-advance every second frame: 0,1,1,2,2,3,3,0
    auto_en = 1'b1;
    step();
    for (int f = 1; f <= 8; f++) begin
      logic [1:0] exp_pat;
      exp_pat = 2'(f / 2);
      step();
      fb();
      chk($sformatf("auto_f%0d", f), 32'(pat_sel), 32'(exp_pat));
    end

    // Dropping auto_en mid-count restarts the count
    fb();
    chk("auto_cnt1", 32'(pat_sel), 32'd0);
    auto_en = 1'b0;
    step();
    auto_en = 1'b1;
    step();
    fb();
    chk("auto_restart", 32'(pat_sel), 32'd0);
    fb();
    chk("auto_after_restart", 32'(pat_sel), 32'd1);

    // Pending request and auto expiry on the same boundary: one advance
    fb();
    chk("coll_pre", 32'(pat_sel), 32'd1);
    next_req = 1'b1;
    step();
    next_req = 1'b0;
    chk("coll_pend", 32'(pend), 32'd1);
    step();
    fb();
    chk("coll_single_adv", 32'(pat_sel), 32'd2);
    chk("coll_pend_clr", 32'(pend), 32'd0);

    // Request arriving on a boundary cycle waits for the next boundary
    auto_en = 1'b0;
    step();
    h_cnt = 11'd0; v_cnt = 11'd0;
    next_req = 1'b1;
    step();
    next_req = 1'b0;
    mid();
    chk("fbreq_ack", 32'(next_ack), 32'd1);
    chk("fbreq_pend", 32'(pend), 32'd1);
    chk("fbreq_pat_hold", 32'(pat_sel), 32'd2);
    step();
    fb();
    chk("fbreq_adv", 32'(pat_sel), 32'd3);

    // A held request re-requests once back in SHOW
    next_req = 1'b1;
    step();
    step();
    fb();
    chk("held_adv", 32'(pat_sel), 32'd0);
    step();
    chk("held_reack", 32'(next_ack), 32'd1);
    next_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
